usbf_sync_fifo: RTL and testbench
=================================

# usbf_sync_fifo

Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides, used between the UTMI receive/transmit byte paths and endpoint buffer logic of the USB 2.0 device controller. It absorbs byte-rate mismatch and backpressure between the packet engine and the endpoint side. It also reports occupancy, full, empty and almost-full status to the protocol layer.

## Interface
- DW, 8, data width in bits
- AW, 4, address width; depth = 2^AW entries (16)
- AF_LVL, 12, almost_full asserts when count >= AF_LVL; legal range 1..2^AW
- clk  input  1  clock; one clock, all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- flush  input  1  synchronous clear of contents; data is discarded
- i_valid  input  1  write request
- i_ready  output  1  FIFO can accept a write
- i_data  input  DW  write data
- o_valid  output  1  head entry available
- o_ready  input  1  consumer accepts the head entry
- o_data  output  DW  head entry
- count  output  AW+1  current occupancy, 0..2^AW
- full  output  1  count == 2^AW
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LVL

## Operation
- Storage: 2^AW x DW register array, no reset on data bits. Write pointer and read pointer are AW+1 bits each and reset to 0.
- Push: occurs when i_valid & i_ready. The FIFO writes i_data to mem[wr_ptr[AW-1:0]] and increments wr_ptr.
- Pop: occurs when o_valid & o_ready. The FIFO increments rd_ptr.
- Pointer wrap: natural modulo-2^(AW+1) rollover.
- count = wr_ptr - rd_ptr, computed in AW+1 bits.
- full: the low AW bits of the two pointers are equal and the MSBs differ.
- empty: the two pointers are equal.
- i_ready = !full & !rst & !flush. A pop in the same cycle does not free a slot for a write while full; there is no write-through when full.
- o_valid = !empty. o_data = mem[rd_ptr[AW-1:0]] when o_valid, otherwise all zeros.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Push while empty: no bypass. The entry is visible on o_valid/o_data the next cycle.
- Pop while empty: impossible because o_valid=0. o_ready is ignored.
- Push while full: impossible because i_ready=0. i_valid and i_data are ignored, and no error is flagged (this is normal backpressure).
- Priority: rst > flush > push/pop.
  - rst or flush sets both pointers to 0 on the next edge.
  - A push or pop presented in the same cycle is discarded.
- Reset or flush mid-stream: all entries are lost. Stale array contents must never reappear on o_data, because o_data is zeroed whenever the FIFO is empty.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - o_valid=0, o_data=0, count=0, empty=1, full=0, almost_full=0.
  - i_ready=1, provided rst and flush are both low.
- While rst or flush is high, i_ready=0 combinationally.
- Write-to-read latency: a push at edge N gives o_valid=1 with that data after edge N, i.e. usable in cycle N+1.
- Pop takes effect at the edge. The next entry, or o_valid=0, appears in the following cycle.
- All status outputs (count, full, empty, almost_full) are derived from the registered pointers. They change only after a clock edge.
- Sustained throughput: 1 push and 1 pop per cycle, provided the FIFO is neither full nor empty.
- No combinational path from i_valid to o_valid. No path from o_ready to i_ready.

## Test plan
- Reset then fill:
  - Stimulus: rst for 2 cycles, then push 0x00..0x0F on 16 consecutive cycles with o_ready=0.
  - Required: count steps 1..16, almost_full rises when count reaches 12, full=1 and i_ready=0 after the 16th push, and a 17th i_valid with 0xAA is not stored.
- Drain:
  - Stimulus: from full, o_ready=1 for 16 cycles.
  - Required: o_data sequence 0x00..0x0F, then empty=1, o_valid=0 and o_data=0.
- Streaming wrap-around:
  - Stimulus: hold i_valid=o_ready=1 for 40 cycles with an incrementing byte pattern, starting from count=3.
  - Required: count stays at 3, the output order matches the input order, and no data is lost across both pointer wraps.
- Full plus simultaneous pop:
  - Stimulus: at full, i_valid=1 and o_ready=1 in the same cycle.
  - Required: only the pop occurs, count goes 16->15, and the pushed byte is dropped.
- Flush mid-stream:
  - Stimulus: with count=7, assert flush for 1 cycle together with i_valid=1 and i_data=0x55.
  - Required: i_ready=0 during the flush cycle, count=0 and o_valid=0 the next cycle, and 0x55 is never output.
- Reset mid-operation:
  - Stimulus: with count=9, assert rst for 1 cycle while o_ready=1.
  - Required: next cycle count=0, empty=1, o_data=0; a subsequent push of 0x3C appears on o_data one cycle later.

Source files
------------

// File: rtl/usbf_sync_fifo.sv
// usbf_sync_fifo: single-clock first-word-fall-through FIFO with valid/ready on both sides
module usbf_sync_fifo #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full
);
    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          push, pop;
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty       = wr_ptr_q == rd_ptr_q;
        almost_full = count >= (AW+1)'(AF_LVL);
        i_ready     = !full && !rst && !flush;
        o_valid     = !empty;
        o_data      = o_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        push        = i_valid && i_ready;
        pop         = o_valid && o_ready;
        wr_ptr_d    = (rst || flush) ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = (rst || flush) ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    // Data array is deliberately not reset; o_data masking hides stale entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
endmodule

// File: tb/tb_usbf_sync_fifo.sv
// tb_usbf_sync_fifo: table-driven vectors plus queue scoreboard for usbf_sync_fifo
module tb_usbf_sync_fifo;
    logic       clk = 1'b0;
    logic       rst, flush, i_valid, i_ready, o_valid, o_ready, full, empty, almost_full;
    logic [7:0] i_data, o_data;
    logic [4:0] count;
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       r, f, iv, ordy;
        logic [7:0] d;
        int         cnt;
    } vec_t;
    vec_t tbl[36];

    always #5 clk = ~clk;

    usbf_sync_fifo #(.DW(8), .AW(4), .AF_LVL(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv, input logic ordy, input logic [7:0] d);
        logic       exp_ir;
        logic [7:0] exp_od;
        int         n;
        rst = r; flush = f; i_valid = iv; o_ready = ordy; i_data = d;
        #1;
        n      = sb.size();
        exp_ir = (n != 16) && !r && !f;
        exp_od = (n != 0) ? sb[0] : 8'h00;
        chk("i_ready", 32'(i_ready), 32'(exp_ir));
        chk("o_valid", 32'(o_valid), 32'(n != 0));
        chk("o_data", 32'(o_data), 32'(exp_od));
        @(posedge clk);
        if (r || f) sb.delete();
        else begin
            if (ordy && n != 0) void'(sb.pop_front());
            if (iv && exp_ir) sb.push_back(d);
        end
        #1;
        n = sb.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == 16));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 12));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        for (int i = 0; i < 16; i++) tbl[2+i] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'(i), i + 1};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 16};
        for (int i = 0; i < 16; i++) tbl[19+i] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15 - i};
        tbl[35] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};

        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = 8'h00;
        @(posedge clk);
        #1;

        // reset, fill to full with a rejected 17th write, then drain
        for (int k = 0; k < 36; k++) begin
            cyc(tbl[k].r, tbl[k].f, tbl[k].iv, tbl[k].ordy, tbl[k].d);
            chk("tbl_count", 32'(count), 32'(tbl[k].cnt));
        end

        // streaming across both pointer wraps at constant occupancy
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(i + 3));
            chk("stream_count", 32'(count), 32'd3);
        end

        // full plus simultaneous pop: only the pop happens
        for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        chk("full_reached", 32'(full), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk("full_pop_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("drained", 32'(empty), 32'd1);

        // flush mid-stream discards contents and the coincident write
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("flush_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // reset mid-operation, then a fresh push appears one cycle later
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
        chk("post_rst_o_data", 32'(o_data), 32'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
